// File: rtl/tlb_cfg_lite_regfile.sv
// tlb_cfg_lite_regfile: AXI-Lite register file holding NUM_ENTRIES TLB entries.
// Each entry is four 32-bit words: first (0x0), last (0x4), base (0x8) and flags (0xC).
// Only flags[1:0] are stored (bit0 valid, bit1 read_only).
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   aw_*, w_*, b_*         AXI-Lite write address / data / response channels
//   ar_*, r_*              AXI-Lite read address / data channels
//   entries_o              entry e at [128e +: 128] = {flags, base, last, first}
//   cfg_update_o           one-cycle pulse per committed in-range write
module tlb_cfg_lite_regfile #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned AXI_LITE_AW = 32,
    parameter int unsigned AXI_LITE_DW = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [AXI_LITE_AW-1:0]       aw_addr_i,
    input  logic                         aw_valid_i,
    output logic                         aw_ready_o,
    input  logic [AXI_LITE_DW-1:0]       w_data_i,
    input  logic [AXI_LITE_DW/8-1:0]     w_strb_i,
    input  logic                         w_valid_i,
    output logic                         w_ready_o,
    output logic [1:0]                   b_resp_o,
    output logic                         b_valid_o,
    input  logic                         b_ready_i,
    input  logic [AXI_LITE_AW-1:0]       ar_addr_i,
    input  logic                         ar_valid_i,
    output logic                         ar_ready_o,
    output logic [AXI_LITE_DW-1:0]       r_data_o,
    output logic [1:0]                   r_resp_o,
    output logic                         r_valid_o,
    input  logic                         r_ready_i,
    output logic [NUM_ENTRIES*128-1:0]   entries_o,
    output logic                         cfg_update_o
);

    localparam int unsigned DW       = AXI_LITE_DW;
    localparam int unsigned SW       = AXI_LITE_DW / 8;
    localparam int unsigned IdxW     = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [16:0] RangeEnd = 17'(16 * NUM_ENTRIES);
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    localparam logic W_IDLE = 1'b0;
    localparam logic W_RESP = 1'b1;
    localparam logic R_IDLE = 1'b0;
    localparam logic R_RESP = 1'b1;

    // Register array
    logic [DW-1:0] first_q [NUM_ENTRIES];
    logic [DW-1:0] last_q  [NUM_ENTRIES];
    logic [DW-1:0] base_q  [NUM_ENTRIES];
    logic [1:0]    flags_q [NUM_ENTRIES];

    // Write path state
    logic          w_state_q;
    logic          aw_held_q;
    logic          w_held_q;
    logic [15:2]   aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic          b_valid_q;
    logic [1:0]    b_resp_q;
    logic          cfg_update_q;

    // Read path state
    logic          r_state_q;
    logic          r_valid_q;
    logic [1:0]    r_resp_q;
    logic [DW-1:0] r_data_q;

    logic            wr_in_range;
    logic            wr_fire;
    logic            do_commit;
    logic [IdxW-1:0] wr_idx;
    logic            rd_in_range;
    logic [IdxW-1:0] rd_idx;
    logic [DW-1:0]   rd_word;

    // Upper address bits and addr[1:0] are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{aw_addr_i, ar_addr_i};

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                  input logic [DW-1:0] new_val,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    assign wr_in_range = {1'b0, aw_addr_q, 2'b00} < RangeEnd;
    assign wr_idx      = aw_addr_q[4 +: IdxW];
    // Commit happens in the cycle after both AW and W are held.
    assign wr_fire     = (w_state_q == W_IDLE) && aw_held_q && w_held_q;
    assign do_commit   = wr_fire && wr_in_range;

    assign rd_in_range = {1'b0, ar_addr_i[15:0]} < RangeEnd;
    assign rd_idx      = ar_addr_i[4 +: IdxW];

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            case (ar_addr_i[3:2])
                2'd0:    rd_word = first_q[rd_idx];
                2'd1:    rd_word = last_q[rd_idx];
                2'd2:    rd_word = base_q[rd_idx];
                default: rd_word = {{(DW-2){1'b0}}, flags_q[rd_idx]};
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                first_q[e] <= '0;
                last_q[e]  <= '0;
                base_q[e]  <= '0;
                flags_q[e] <= '0;
            end
        end else if (do_commit) begin
            case (aw_addr_q[3:2])
                2'd0: first_q[wr_idx] <= merge_bytes(first_q[wr_idx], w_data_q, w_strb_q);
                2'd1: last_q[wr_idx]  <= merge_bytes(last_q[wr_idx], w_data_q, w_strb_q);
                2'd2: base_q[wr_idx]  <= merge_bytes(base_q[wr_idx], w_data_q, w_strb_q);
                default: begin
                    if (w_strb_q[0]) flags_q[wr_idx] <= w_data_q[1:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_state_q    <= W_IDLE;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            b_valid_q    <= 1'b0;
            b_resp_q     <= RespOkay;
            cfg_update_q <= 1'b0;
        end else begin
            cfg_update_q <= 1'b0;
            case (w_state_q)
                W_IDLE: begin
                    if (aw_valid_i && aw_ready_o) begin
                        aw_held_q <= 1'b1;
                        aw_addr_q <= aw_addr_i[15:2];
                    end
                    if (w_valid_i && w_ready_o) begin
                        w_held_q <= 1'b1;
                        w_data_q <= w_data_i;
                        w_strb_q <= w_strb_i;
                    end
                    if (wr_fire) begin
                        aw_held_q    <= 1'b0;
                        w_held_q     <= 1'b0;
                        b_valid_q    <= 1'b1;
                        b_resp_q     <= wr_in_range ? RespOkay : RespSlvErr;
                        cfg_update_q <= wr_in_range;
                        w_state_q    <= W_RESP;
                    end
                end
                default: begin
                    if (b_ready_i) begin
                        b_valid_q <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            r_valid_q <= 1'b0;
            r_resp_q  <= RespOkay;
            r_data_q  <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    // Array is read before any same-edge commit lands, so a
                    // colliding read returns the pre-write value.
                    if (ar_valid_i) begin
                        r_data_q  <= rd_word;
                        r_resp_q  <= rd_in_range ? RespOkay : RespSlvErr;
                        r_valid_q <= 1'b1;
                        r_state_q <= R_RESP;
                    end
                end
                default: begin
                    if (r_ready_i) begin
                        r_valid_q <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign aw_ready_o   = (w_state_q == W_IDLE) && !aw_held_q;
    assign w_ready_o    = (w_state_q == W_IDLE) && !w_held_q;
    assign b_valid_o    = b_valid_q;
    assign b_resp_o     = b_resp_q;
    assign cfg_update_o = cfg_update_q;
    assign ar_ready_o   = (r_state_q == R_IDLE);
    assign r_valid_o    = r_valid_q;
    assign r_resp_o     = r_resp_q;
    assign r_data_o     = r_data_q;

    always_comb begin
        entries_o = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            entries_o[128*e +: 128] = {{(DW-2){1'b0}}, flags_q[e], base_q[e], last_q[e],
                                       first_q[e]};
        end
    end

endmodule

// File: tb/tb_tlb_cfg_lite_regfile.sv
// Scoreboard bench for tlb_cfg_lite_regfile: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them on every handshake.
module tb_tlb_cfg_lite_regfile;

    localparam int N = 8;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [31:0]      aw_addr_i;
    logic             aw_valid_i;
    logic             aw_ready_o;
    logic [31:0]      w_data_i;
    logic [3:0]       w_strb_i;
    logic             w_valid_i;
    logic             w_ready_o;
    logic [1:0]       b_resp_o;
    logic             b_valid_o;
    logic             b_ready_i;
    logic [31:0]      ar_addr_i;
    logic             ar_valid_i;
    logic             ar_ready_o;
    logic [31:0]      r_data_o;
    logic [1:0]       r_resp_o;
    logic             r_valid_o;
    logic             r_ready_i;
    logic [N*128-1:0] entries_o;
    logic             cfg_update_o;

    tlb_cfg_lite_regfile #(
        .NUM_ENTRIES(N),
        .AXI_LITE_AW(32),
        .AXI_LITE_DW(32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .aw_addr_i   (aw_addr_i),
        .aw_valid_i  (aw_valid_i),
        .aw_ready_o  (aw_ready_o),
        .w_data_i    (w_data_i),
        .w_strb_i    (w_strb_i),
        .w_valid_i   (w_valid_i),
        .w_ready_o   (w_ready_o),
        .b_resp_o    (b_resp_o),
        .b_valid_o   (b_valid_o),
        .b_ready_i   (b_ready_i),
        .ar_addr_i   (ar_addr_i),
        .ar_valid_i  (ar_valid_i),
        .ar_ready_o  (ar_ready_o),
        .r_data_o    (r_data_o),
        .r_resp_o    (r_resp_o),
        .r_valid_o   (r_valid_o),
        .r_ready_i   (r_ready_i),
        .entries_o   (entries_o),
        .cfg_update_o(cfg_update_o)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int b_seen = 0, b_exp = 0;
    int r_seen = 0, r_exp = 0;
    int cfg_cnt = 0;

    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        failed++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [31:0] ent_word(input int e, input int w);
        return entries_o[128*e + 32*w +: 32];
    endfunction

    // Monitor: pops expected responses on each handshake.
    always @(negedge clk) begin
        if (b_valid_o === 1'b1 && b_ready_i) begin
            if (bq.size() == 0) timeout_fail("b_unexpected");
            else check("b_resp", 64'(b_resp_o), 64'(bq.pop_front()));
            b_seen++;
        end
        if (r_valid_o === 1'b1 && r_ready_i) begin
            if (rq.size() == 0) timeout_fail("r_unexpected");
            else check("r_resp_data", 64'({r_resp_o, r_data_o}), 64'(rq.pop_front()));
            r_seen++;
        end
        if (cfg_update_o === 1'b1) cfg_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int aw_dly, input int w_dly,
                               input logic [1:0] exp_resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        bq.push_back(exp_resp);
        b_exp++;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (cyc == aw_dly && !aw_done) begin aw_valid_i = 1; aw_addr_i = addr; end
            if (cyc == w_dly && !w_done) begin
                w_valid_i = 1; w_data_i = data; w_strb_i = strb;
            end
            @(negedge clk);
            aw_hs = aw_valid_i && aw_ready_o;
            w_hs  = w_valid_i && w_ready_o;
            tick();
            if (aw_hs) begin aw_done = 1; aw_valid_i = 0; end
            if (w_hs) begin w_done = 1; w_valid_i = 0; end
            cyc++;
        end
        if (!(aw_done && w_done)) begin
            aw_valid_i = 0; w_valid_i = 0;
            timeout_fail("write_handshake");
        end
    endtask

    task automatic wait_b();
        int n = 0;
        while (b_seen < b_exp && n < 100) begin tick(); n++; end
        if (b_seen < b_exp) timeout_fail("wait_b");
    endtask

    task automatic wait_r();
        int n = 0;
        while (r_seen < r_exp && n < 100) begin tick(); n++; end
        if (r_seen < r_exp) timeout_fail("wait_r");
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        issue_write(addr, data, strb, 0, 0, exp_resp);
        wait_b();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [1:0] exp_resp,
                           input logic [31:0] exp_data);
        bit hs = 0;
        int n = 0;
        rq.push_back({exp_resp, exp_data});
        r_exp++;
        ar_valid_i = 1;
        ar_addr_i  = addr;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = ar_ready_o;
            tick();
            n++;
        end
        ar_valid_i = 0;
        if (!hs) timeout_fail("read_handshake");
        wait_r();
    endtask

    logic [N*128-1:0] snap;
    int               cfg0;

    initial begin
        rst_ni = 0; aw_addr_i = 0; aw_valid_i = 0; w_data_i = 0; w_strb_i = 0;
        w_valid_i = 0; b_ready_i = 1; ar_addr_i = 0; ar_valid_i = 0; r_ready_i = 1;
        tick(); tick();
        rst_ni = 1;
        tick();
        @(negedge clk);
        check("rst_aw_ready", 64'(aw_ready_o), 1);
        check("rst_w_ready", 64'(w_ready_o), 1);
        check("rst_ar_ready", 64'(ar_ready_o), 1);
        check("rst_valids", 64'({b_valid_o, r_valid_o, cfg_update_o}), 0);
        check("rst_resp_data", 64'({b_resp_o, r_resp_o, r_data_o}), 0);
        check("rst_entries_zero", 64'(entries_o == '0), 1);
        tick();

        // AW and W together
        cfg0 = cfg_cnt;
        do_write(32'h0010, 32'h8000_1000, 4'hF, 2'b00);
        check("e1_first", 64'(entries_o[159:128]), 64'h8000_1000);
        check("cfg_pulse_once", 64'(cfg_cnt - cfg0), 1);

        // W three cycles before AW
        cfg0 = cfg_cnt;
        issue_write(32'h002C, 32'hFFFF_FFFF, 4'h3, 3, 0, 2'b00);
        check("no_commit_before_aw", 64'({cfg_cnt - cfg0, ent_word(2, 3)}), 0);
        wait_b();
        check("e2_flags", 64'(ent_word(2, 3)), 64'h3);
        do_read(32'h002C, 2'b00, 32'h0000_0003);

        // Partial strobes
        do_write(32'h0020, 32'h1122_3344, 4'hF, 2'b00);
        do_write(32'h0020, 32'hAABB_CCDD, 4'h5, 2'b00);
        do_read(32'h0020, 2'b00, 32'h11BB_33DD);

        // Zero strobe commits nothing, addr[1:0] ignored on read
        do_write(32'h0010, 32'h0000_0000, 4'h0, 2'b00);
        do_read(32'h0013, 2'b00, 32'h8000_1000);

        // Last in-range word and first out-of-range address
        do_write(32'h007C, 32'hFFFF_FFFF, 4'hF, 2'b00);
        do_read(32'h007C, 2'b00, 32'h0000_0003);
        do_read(32'h0080, 2'b10, 32'h0);

        // Out-of-range write/read
        snap = entries_o;
        cfg0 = cfg_cnt;
        do_write(32'h1000, 32'hDEAD_BEEF, 4'hF, 2'b10);
        do_read(32'h1000, 2'b10, 32'h0);
        check("oor_entries_unchanged", 64'(entries_o == snap), 1);
        check("oor_no_cfg_update", 64'(cfg_cnt - cfg0), 0);

        // Back-pressure on B
        b_ready_i = 0;
        issue_write(32'h0014, 32'h0000_0022, 4'hF, 0, 0, 2'b00);
        begin
            int n = 0;
            while (!b_valid_o && n < 20) begin tick(); n++; end
            if (!b_valid_o) timeout_fail("b_valid_rise");
        end
        aw_valid_i = 1; aw_addr_i = 32'h0018;
        w_valid_i = 1; w_data_i = 32'h0000_0099; w_strb_i = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_b_valid", 64'(b_valid_o), 1);
            check("bp_b_resp", 64'(b_resp_o), 0);
            check("bp_aw_ready", 64'(aw_ready_o), 0);
            check("bp_w_ready", 64'(w_ready_o), 0);
            tick();
        end
        aw_valid_i = 0; w_valid_i = 0;
        b_ready_i = 1;
        wait_b();
        tick();
        check("bp_e1_last", 64'(ent_word(1, 1)), 64'h22);
        check("bp_e1_base_untouched", 64'(ent_word(1, 2)), 0);

        // Read colliding with commit to same word
        do_write(32'h0004, 32'h0000_0011, 4'hF, 2'b00);
        bq.push_back(2'b00); b_exp++;
        rq.push_back({2'b00, 32'h0000_0011}); r_exp++;
        aw_valid_i = 1; aw_addr_i = 32'h0004;
        w_valid_i = 1; w_data_i = 32'h0000_0055; w_strb_i = 4'hF;
        tick();
        aw_valid_i = 0; w_valid_i = 0;
        ar_valid_i = 1; ar_addr_i = 32'h0004;
        tick();
        ar_valid_i = 0;
        check("collide_cfg_update", 64'(cfg_update_o), 1);
        wait_r();
        wait_b();
        do_read(32'h0004, 2'b00, 32'h0000_0055);

        // Reset mid-transaction
        cfg0 = cfg_cnt;
        aw_valid_i = 1; aw_addr_i = 32'h0030;
        tick();
        aw_valid_i = 0;
        w_valid_i = 1; w_data_i = 32'h1234_5678; w_strb_i = 4'hF;
        rst_ni = 0;
        tick(); tick();
        w_valid_i = 0;
        rst_ni = 1;
        @(negedge clk);
        check("mrst_readies", 64'({aw_ready_o, w_ready_o, ar_ready_o}), 64'h7);
        check("mrst_valids", 64'({b_valid_o, r_valid_o}), 0);
        check("mrst_entries_zero", 64'(entries_o == '0), 1);
        tick(); tick(); tick();
        check("mrst_no_commit", 64'({cfg_cnt - cfg0, 31'(entries_o == '0)}), 1);
        check("queues_drained", 64'(bq.size() + rq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
